// File: rtl/procyon_mhq_entry_beats_if.sv
// Bus between one MHQ entry and the MHQ top: lookup, update, BIU handshake/beats, fill launch.
// The entry connects through 'slave'; the MHQ top (or a bench) drives through 'master'.
interface procyon_mhq_entry_beats_if #(
  parameter int OPTN_ADDR_WIDTH    = 32,
  parameter int OPTN_DC_LINE_SIZE  = 32,
  parameter int OPTN_BIU_DATA_SIZE = 8
);
  localparam int DC_LINE_WIDTH   = OPTN_DC_LINE_SIZE * 8;
  localparam int DC_OFFSET_WIDTH = $clog2(OPTN_DC_LINE_SIZE);
  localparam int LINE_ADDR_WIDTH = OPTN_ADDR_WIDTH - DC_OFFSET_WIDTH;

  logic                          o_mhq_entry_valid;
  logic                          o_mhq_entry_complete;
  logic                          o_mhq_entry_dirty;
  logic [LINE_ADDR_WIDTH-1:0]    o_mhq_entry_addr;
  logic [DC_LINE_WIDTH-1:0]      o_mhq_entry_data;
  logic [OPTN_DC_LINE_SIZE-1:0]  o_mhq_entry_byte_valid;

  logic [LINE_ADDR_WIDTH-1:0]    i_lookup_addr;
  logic [OPTN_DC_LINE_SIZE-1:0]  i_lookup_byte_select;
  logic                          o_lookup_hit;
  logic                          o_lookup_data_ready;

  logic                          i_update_en;
  logic                          i_update_we;
  logic [DC_LINE_WIDTH-1:0]      i_update_wr_data;
  logic [OPTN_DC_LINE_SIZE-1:0]  i_update_byte_select;
  logic [LINE_ADDR_WIDTH-1:0]    i_update_addr;
  logic [DC_OFFSET_WIDTH-1:0]    i_update_offset;

  logic                          o_biu_req;
  logic                          i_biu_req_ack;
  logic                          i_biu_en;
  logic [OPTN_BIU_DATA_SIZE*8-1:0] i_biu_data;
  logic                          i_fill_launched;

  modport slave (
    output o_mhq_entry_valid, o_mhq_entry_complete, o_mhq_entry_dirty,
           o_mhq_entry_addr, o_mhq_entry_data, o_mhq_entry_byte_valid,
           o_lookup_hit, o_lookup_data_ready, o_biu_req,
    input  i_lookup_addr, i_lookup_byte_select,
           i_update_en, i_update_we, i_update_wr_data, i_update_byte_select,
           i_update_addr, i_update_offset,
           i_biu_req_ack, i_biu_en, i_biu_data, i_fill_launched
  );

  modport master (
    input  o_mhq_entry_valid, o_mhq_entry_complete, o_mhq_entry_dirty,
           o_mhq_entry_addr, o_mhq_entry_data, o_mhq_entry_byte_valid,
           o_lookup_hit, o_lookup_data_ready, o_biu_req,
    output i_lookup_addr, i_lookup_byte_select,
           i_update_en, i_update_we, i_update_wr_data, i_update_byte_select,
           i_update_addr, i_update_offset,
           i_biu_req_ack, i_biu_en, i_biu_data, i_fill_launched
  );
endinterface

// File: rtl/procyon_mhq_entry_beats.sv
// One MHQ slot: tracks a line miss, fills it beat by beat from the BIU, merges stores per byte.
// Optional PROCYON_MHQ_CRITICAL_BEAT_FIRST_EN starts the fill at the beat holding the requested offset.
module procyon_mhq_entry_beats #(
  parameter int OPTN_ADDR_WIDTH    = 32,
  parameter int OPTN_DC_LINE_SIZE  = 32,
  parameter int OPTN_BIU_DATA_SIZE = 8
) (
  input  logic                           clk,
  input  logic                           n_rst,
  procyon_mhq_entry_beats_if.slave       bus
);
  localparam int DC_LINE_WIDTH   = OPTN_DC_LINE_SIZE * 8;
  localparam int DC_OFFSET_WIDTH = $clog2(OPTN_DC_LINE_SIZE);
  localparam int LINE_ADDR_WIDTH = OPTN_ADDR_WIDTH - DC_OFFSET_WIDTH;
  localparam int BEAT_COUNT      = OPTN_DC_LINE_SIZE / OPTN_BIU_DATA_SIZE;
  localparam int BEAT_IDX_WIDTH  = (BEAT_COUNT > 1) ? $clog2(BEAT_COUNT) : 1;
  localparam int BIU_OFFSET_WIDTH = $clog2(OPTN_BIU_DATA_SIZE);

  typedef enum logic [1:0] {
    INVALID  = 2'd0,
    PENDING  = 2'd1,
    FILLING  = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic                          dirty_q, dirty_d;
  logic [OPTN_DC_LINE_SIZE-1:0]  byte_valid_q, byte_valid_d;
  logic [OPTN_DC_LINE_SIZE-1:0]  byte_updated_q, byte_updated_d;
  logic [DC_LINE_WIDTH-1:0]      data_q, data_d;
  logic [LINE_ADDR_WIDTH-1:0]    addr_q;
  logic [BEAT_IDX_WIDTH-1:0]     beat_cnt_q;
  logic [BEAT_IDX_WIDTH-1:0]     beat_inc;
  logic [BEAT_IDX_WIDTH-1:0]     last_beat;
  logic [BEAT_IDX_WIDTH-1:0]     start_beat;

  logic allocate;
  logic update_ok;
  logic store_en;
  logic beat_fire;

  assign allocate  = bus.i_update_en & (state_q == INVALID);
  // A fill launch in COMPLETE takes priority; a colliding update is dropped.
  assign update_ok = bus.i_update_en & ~((state_q == COMPLETE) & bus.i_fill_launched);
  assign store_en  = update_ok & bus.i_update_we;
  assign beat_fire = (state_q == FILLING) & bus.i_biu_en;

  assign beat_inc  = (BEAT_COUNT == 1) ? '0 : beat_cnt_q + BEAT_IDX_WIDTH'(1);
  assign last_beat = (BEAT_COUNT == 1) ? '0 : start_beat - BEAT_IDX_WIDTH'(1);

`ifdef PROCYON_MHQ_CRITICAL_BEAT_FIRST_EN
  logic [BEAT_IDX_WIDTH-1:0] start_beat_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      start_beat_q <= '0;
    end else if (allocate) begin
      start_beat_q <= BEAT_IDX_WIDTH'(bus.i_update_offset >> BIU_OFFSET_WIDTH);
    end
  end

  assign start_beat = start_beat_q;
`else
  logic unused_offset;

  assign unused_offset = ^bus.i_update_offset;
  assign start_beat    = '0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= INVALID;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INVALID:  if (bus.i_update_en) state_d = PENDING;
      PENDING:  if (bus.i_biu_req_ack) state_d = FILLING;
      FILLING:  if (bus.i_biu_en && (beat_cnt_q == last_beat)) state_d = COMPLETE;
      COMPLETE: if (bus.i_fill_launched) state_d = INVALID;
      default:  state_d = INVALID;
    endcase
  end

  // Stores always beat BIU data; a beat byte never overwrites a store-updated byte.
  always_comb begin
    data_d         = data_q;
    byte_valid_d   = byte_valid_q;
    byte_updated_d = byte_updated_q;
    dirty_d        = dirty_q;

    if (allocate) begin
      dirty_d = bus.i_update_we;
    end else if (update_ok) begin
      dirty_d = dirty_q | bus.i_update_we;
    end

    for (int b = 0; b < OPTN_DC_LINE_SIZE; b++) begin
      if (allocate) begin
        byte_valid_d[b]   = store_en & bus.i_update_byte_select[b];
        byte_updated_d[b] = store_en & bus.i_update_byte_select[b];
        if (store_en && bus.i_update_byte_select[b]) begin
          data_d[b*8 +: 8] = bus.i_update_wr_data[b*8 +: 8];
        end
      end else if (store_en && bus.i_update_byte_select[b]) begin
        byte_valid_d[b]   = 1'b1;
        byte_updated_d[b] = 1'b1;
        data_d[b*8 +: 8]  = bus.i_update_wr_data[b*8 +: 8];
      end else if (beat_fire && !byte_updated_q[b] &&
                   (BEAT_IDX_WIDTH'(b / OPTN_BIU_DATA_SIZE) == beat_cnt_q)) begin
        byte_valid_d[b]  = 1'b1;
        data_d[b*8 +: 8] = bus.i_biu_data[(b % OPTN_BIU_DATA_SIZE)*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dirty_q        <= 1'b0;
      byte_valid_q   <= '0;
      byte_updated_q <= '0;
      data_q         <= '0;
      addr_q         <= '0;
      beat_cnt_q     <= '0;
    end else begin
      dirty_q        <= dirty_d;
      byte_valid_q   <= byte_valid_d;
      byte_updated_q <= byte_updated_d;
      data_q         <= data_d;
      if (allocate) begin
        addr_q <= bus.i_update_addr;
      end
      if ((state_q == PENDING) && bus.i_biu_req_ack) begin
        beat_cnt_q <= start_beat;
      end else if (beat_fire) begin
        beat_cnt_q <= beat_inc;
      end
    end
  end

  assign bus.o_mhq_entry_valid      = (state_q != INVALID);
  assign bus.o_mhq_entry_complete   = (state_q == COMPLETE);
  assign bus.o_mhq_entry_dirty      = dirty_q;
  assign bus.o_mhq_entry_addr       = addr_q;
  assign bus.o_mhq_entry_data       = data_q;
  assign bus.o_mhq_entry_byte_valid = byte_valid_q;
  assign bus.o_biu_req              = (state_q == PENDING);

  assign bus.o_lookup_hit        = (state_q != INVALID) && (addr_q == bus.i_lookup_addr);
  assign bus.o_lookup_data_ready = bus.o_lookup_hit &&
                                   ((bus.i_lookup_byte_select & ~byte_valid_q) == '0);
endmodule

// File: tb/tb_procyon_mhq_entry_beats.sv
// Directed bench for procyon_mhq_entry_beats at default parameters (4 beats of 8 bytes per 32-byte line).
module tb_procyon_mhq_entry_beats;
  localparam int LA = 27;
  localparam int LW = 256;

  logic clk;
  logic n_rst;
  int   total = 0;
  int   bad   = 0;

  procyon_mhq_entry_beats_if #(.OPTN_ADDR_WIDTH(32), .OPTN_DC_LINE_SIZE(32), .OPTN_BIU_DATA_SIZE(8)) bus ();

  procyon_mhq_entry_beats #(.OPTN_ADDR_WIDTH(32), .OPTN_DC_LINE_SIZE(32), .OPTN_BIU_DATA_SIZE(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_lookup_addr        = '0;
    bus.i_lookup_byte_select = '0;
    bus.i_update_en          = 1'b0;
    bus.i_update_we          = 1'b0;
    bus.i_update_wr_data     = '0;
    bus.i_update_byte_select = '0;
    bus.i_update_addr        = '0;
    bus.i_update_offset      = '0;
    bus.i_biu_req_ack        = 1'b0;
    bus.i_biu_en             = 1'b0;
    bus.i_biu_data           = '0;
    bus.i_fill_launched      = 1'b0;
  endtask

  task automatic allocate(input logic [LA-1:0] a, input logic we, input logic [LW-1:0] wd,
                          input logic [31:0] sel, input logic [4:0] off);
    bus.i_update_en = 1'b1; bus.i_update_we = we; bus.i_update_wr_data = wd;
    bus.i_update_byte_select = sel; bus.i_update_addr = a; bus.i_update_offset = off;
    step();
    bus.i_update_en = 1'b0; bus.i_update_we = 1'b0; bus.i_update_byte_select = '0;
  endtask

  task automatic ack();
    bus.i_biu_req_ack = 1'b1;
    step();
    bus.i_biu_req_ack = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d);
    bus.i_biu_en = 1'b1; bus.i_biu_data = d;
    step();
    bus.i_biu_en = 1'b0;
  endtask

  task automatic launch();
    bus.i_fill_launched = 1'b1;
    step();
    bus.i_fill_launched = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (bus.o_mhq_entry_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", bus.o_mhq_entry_valid); end
    total++; if (bus.o_mhq_entry_complete !== 1'b0) begin bad++; $display("FAIL rst_complete got %b want 0", bus.o_mhq_entry_complete); end
    total++; if (bus.o_mhq_entry_dirty !== 1'b0) begin bad++; $display("FAIL rst_dirty got %b want 0", bus.o_mhq_entry_dirty); end
    total++; if (bus.o_mhq_entry_addr !== '0) begin bad++; $display("FAIL rst_addr got %h want 0", bus.o_mhq_entry_addr); end
    total++; if (bus.o_mhq_entry_data !== '0) begin bad++; $display("FAIL rst_data got %h want 0", bus.o_mhq_entry_data); end
    total++; if (bus.o_mhq_entry_byte_valid !== 32'h0) begin bad++; $display("FAIL rst_byte_valid got %h want 0", bus.o_mhq_entry_byte_valid); end
    total++; if (bus.o_biu_req !== 1'b0) begin bad++; $display("FAIL rst_biu_req got %b want 0", bus.o_biu_req); end
  endtask

  task automatic test_basic_fill();
    logic [LW-1:0] exp_line;
    exp_line = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    allocate(27'h1234, 1'b0, '0, 32'h0, 5'h0);
    total++; if (bus.o_biu_req !== 1'b1) begin bad++; $display("FAIL basic_req_pending got %b want 1", bus.o_biu_req); end
    total++; if (bus.o_mhq_entry_addr !== 27'h1234) begin bad++; $display("FAIL basic_addr got %h want 1234", bus.o_mhq_entry_addr); end
    ack();
    total++; if (bus.o_biu_req !== 1'b0) begin bad++; $display("FAIL basic_req_after_ack got %b want 0", bus.o_biu_req); end
    beat(64'h1111111111111111);
    beat(64'h2222222222222222);
    // Beats 0 and 1 have landed: bytes 0-15 valid.
    bus.i_lookup_addr = 27'h1234; bus.i_lookup_byte_select = 32'h0000FF00; #1;
    total++; if (bus.o_lookup_hit !== 1'b1) begin bad++; $display("FAIL lookup_hit got %b want 1", bus.o_lookup_hit); end
    total++; if (bus.o_lookup_data_ready !== 1'b1) begin bad++; $display("FAIL lookup_ready got %b want 1", bus.o_lookup_data_ready); end
    bus.i_lookup_byte_select = 32'h00010000; #1;
    total++; if (bus.o_lookup_hit !== 1'b1) begin bad++; $display("FAIL lookup_hit_b16 got %b want 1", bus.o_lookup_hit); end
    total++; if (bus.o_lookup_data_ready !== 1'b0) begin bad++; $display("FAIL lookup_ready_b16 got %b want 0", bus.o_lookup_data_ready); end
    bus.i_lookup_addr = 27'h1235; bus.i_lookup_byte_select = 32'h000000FF; #1;
    total++; if (bus.o_lookup_hit !== 1'b0) begin bad++; $display("FAIL lookup_miss got %b want 0", bus.o_lookup_hit); end
    total++; if (bus.o_lookup_data_ready !== 1'b0) begin bad++; $display("FAIL lookup_miss_ready got %b want 0", bus.o_lookup_data_ready); end
    bus.i_lookup_addr = '0; bus.i_lookup_byte_select = '0;
    beat(64'h3333333333333333);
    total++; if (bus.o_mhq_entry_complete !== 1'b0) begin bad++; $display("FAIL basic_early_complete got %b want 0", bus.o_mhq_entry_complete); end
    beat(64'h4444444444444444);
    total++; if (bus.o_mhq_entry_complete !== 1'b1) begin bad++; $display("FAIL basic_complete got %b want 1", bus.o_mhq_entry_complete); end
    total++; if (bus.o_mhq_entry_data !== exp_line) begin bad++; $display("FAIL basic_data got %h want %h", bus.o_mhq_entry_data, exp_line); end
    total++; if (bus.o_mhq_entry_dirty !== 1'b0) begin bad++; $display("FAIL basic_dirty got %b want 0", bus.o_mhq_entry_dirty); end
    total++; if (bus.o_mhq_entry_byte_valid !== 32'hFFFFFFFF) begin bad++; $display("FAIL basic_byte_valid got %h want ffffffff", bus.o_mhq_entry_byte_valid); end
    launch();
    total++; if (bus.o_mhq_entry_valid !== 1'b0) begin bad++; $display("FAIL basic_launch_valid got %b want 0", bus.o_mhq_entry_valid); end
  endtask

  task automatic test_store_merge();
    logic [LW-1:0] wd;
    wd = '0;
    wd[47:40] = 8'hAB;
    allocate(27'h0055, 1'b1, wd, 32'h00000020, 5'h0);
    total++; if (bus.o_mhq_entry_byte_valid !== 32'h00000020) begin bad++; $display("FAIL store_alloc_bv got %h want 00000020", bus.o_mhq_entry_byte_valid); end
    ack();
    beat(64'hFFFFFFFFFFFFFFFF);
    total++; if (bus.o_mhq_entry_data[63:0] !== 64'hFFFFABFFFFFFFFFF) begin bad++; $display("FAIL store_beat0 got %h want ffffabffffffffff", bus.o_mhq_entry_data[63:0]); end
    total++; if (bus.o_mhq_entry_dirty !== 1'b1) begin bad++; $display("FAIL store_dirty got %b want 1", bus.o_mhq_entry_dirty); end
    total++; if (bus.o_mhq_entry_byte_valid !== 32'h000000FF) begin bad++; $display("FAIL store_bv got %h want 000000ff", bus.o_mhq_entry_byte_valid); end
    beat(64'h0); beat(64'h0); beat(64'h0);
    launch();

    // Store and beat 0 land in the same cycle.
    allocate(27'h0056, 1'b0, '0, 32'h0, 5'h0);
    ack();
    bus.i_update_en = 1'b1; bus.i_update_we = 1'b1; bus.i_update_wr_data = wd;
    bus.i_update_byte_select = 32'h00000020;
    beat(64'hFFFFFFFFFFFFFFFF);
    bus.i_update_en = 1'b0; bus.i_update_we = 1'b0; bus.i_update_byte_select = '0;
    total++; if (bus.o_mhq_entry_data[63:0] !== 64'hFFFFABFFFFFFFFFF) begin bad++; $display("FAIL same_cycle_data got %h want ffffabffffffffff", bus.o_mhq_entry_data[63:0]); end
    total++; if (bus.o_mhq_entry_dirty !== 1'b1) begin bad++; $display("FAIL same_cycle_dirty got %b want 1", bus.o_mhq_entry_dirty); end
    total++; if (bus.o_mhq_entry_addr !== 27'h0056) begin bad++; $display("FAIL merge_addr got %h want 0056", bus.o_mhq_entry_addr); end
    beat(64'h0); beat(64'h0); beat(64'h0);
    launch();
  endtask

  task automatic test_fill_update_collision();
    logic [LW-1:0] wd;
    wd = '0;
    wd[7:0]  = 8'h5A;
    wd[15:8] = 8'h77;
    allocate(27'h0100, 1'b1, wd, 32'h00000001, 5'h0);
    ack();
    beat(64'h1); beat(64'h2); beat(64'h3); beat(64'h4);
    total++; if (bus.o_mhq_entry_complete !== 1'b1) begin bad++; $display("FAIL coll_complete got %b want 1", bus.o_mhq_entry_complete); end
    bus.i_fill_launched = 1'b1; bus.i_update_en = 1'b1; bus.i_update_we = 1'b1;
    bus.i_update_wr_data = wd; bus.i_update_byte_select = 32'h00000002;
    step();
    idle_inputs();
    total++; if (bus.o_mhq_entry_valid !== 1'b0) begin bad++; $display("FAIL coll_valid got %b want 0", bus.o_mhq_entry_valid); end
    total++; if (bus.o_mhq_entry_data[15:8] !== 8'h00) begin bad++; $display("FAIL coll_dropped_store got %h want 00", bus.o_mhq_entry_data[15:8]); end
    allocate(27'h0077, 1'b0, '0, 32'h0, 5'h0);
    total++; if (bus.o_mhq_entry_dirty !== 1'b0) begin bad++; $display("FAIL realloc_dirty got %b want 0", bus.o_mhq_entry_dirty); end
    total++; if (bus.o_mhq_entry_byte_valid !== 32'h0) begin bad++; $display("FAIL realloc_bv got %h want 0", bus.o_mhq_entry_byte_valid); end
    total++; if (bus.o_biu_req !== 1'b1) begin bad++; $display("FAIL realloc_req got %b want 1", bus.o_biu_req); end
    ack();
    beat(64'h0); beat(64'h0); beat(64'h0); beat(64'h0);
    launch();
  endtask

  task automatic test_reset_mid_fill();
    allocate(27'h0200, 1'b1, {LW{1'b1}}, 32'h00000001, 5'h0);
    ack();
    beat(64'hAAAAAAAAAAAAAAAA);
    beat(64'hBBBBBBBBBBBBBBBB);
    n_rst = 1'b0;
    #1;
    total++; if (bus.o_mhq_entry_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got %b want 0", bus.o_mhq_entry_valid); end
    total++; if (bus.o_mhq_entry_byte_valid !== 32'h0) begin bad++; $display("FAIL midrst_bv got %h want 0", bus.o_mhq_entry_byte_valid); end
    total++; if (bus.o_mhq_entry_data !== '0) begin bad++; $display("FAIL midrst_data got %h want 0", bus.o_mhq_entry_data); end
    total++; if (bus.o_mhq_entry_dirty !== 1'b0) begin bad++; $display("FAIL midrst_dirty got %b want 0", bus.o_mhq_entry_dirty); end
    total++; if (bus.o_mhq_entry_addr !== '0) begin bad++; $display("FAIL midrst_addr got %h want 0", bus.o_mhq_entry_addr); end
    step();
    n_rst = 1'b1;
    step();
    allocate(27'h0300, 1'b0, '0, 32'h0, 5'h0);
    total++; if (bus.o_mhq_entry_valid !== 1'b1) begin bad++; $display("FAIL postrst_valid got %b want 1", bus.o_mhq_entry_valid); end
    total++; if (bus.o_mhq_entry_addr !== 27'h0300) begin bad++; $display("FAIL postrst_addr got %h want 0300", bus.o_mhq_entry_addr); end
    ack();
    beat(64'h0); beat(64'h0); beat(64'h0); beat(64'h0);
    total++; if (bus.o_mhq_entry_complete !== 1'b1) begin bad++; $display("FAIL postrst_complete got %b want 1", bus.o_mhq_entry_complete); end
    launch();
  endtask

  task automatic test_beat_order();
    logic [LW-1:0] exp_line;
    logic [31:0]   exp_bv1;
`ifdef PROCYON_MHQ_CRITICAL_BEAT_FIRST_EN
    exp_bv1  = 32'hFF000000;
    exp_line = {64'hA1A1A1A1A1A1A1A1, 64'hD4D4D4D4D4D4D4D4, 64'hC3C3C3C3C3C3C3C3, 64'hB2B2B2B2B2B2B2B2};
`else
    exp_bv1  = 32'h000000FF;
    exp_line = {64'hD4D4D4D4D4D4D4D4, 64'hC3C3C3C3C3C3C3C3, 64'hB2B2B2B2B2B2B2B2, 64'hA1A1A1A1A1A1A1A1};
`endif
    allocate(27'h0400, 1'b0, '0, 32'h0, 5'h18);
    ack();
    beat(64'hA1A1A1A1A1A1A1A1);
    total++; if (bus.o_mhq_entry_byte_valid !== exp_bv1) begin bad++; $display("FAIL order_first_beat got %h want %h", bus.o_mhq_entry_byte_valid, exp_bv1); end
    beat(64'hB2B2B2B2B2B2B2B2);
    beat(64'hC3C3C3C3C3C3C3C3);
    total++; if (bus.o_mhq_entry_complete !== 1'b0) begin bad++; $display("FAIL order_early_complete got %b want 0", bus.o_mhq_entry_complete); end
    beat(64'hD4D4D4D4D4D4D4D4);
    total++; if (bus.o_mhq_entry_complete !== 1'b1) begin bad++; $display("FAIL order_complete got %b want 1", bus.o_mhq_entry_complete); end
    total++; if (bus.o_mhq_entry_data !== exp_line) begin bad++; $display("FAIL order_data got %h want %h", bus.o_mhq_entry_data, exp_line); end
    launch();
  endtask

  initial begin
    n_rst = 1'b0;
    idle_inputs();
    step();
    test_reset();
    step();
    n_rst = 1'b1;
    step();
    test_basic_fill();
    test_store_merge();
    test_fill_update_collision();
    test_reset_mid_fill();
    test_beat_order();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
